data_bus_demux: RTL and testbench
=================================

// Module: data_bus_demux
// PURPOSE
// - Sits between the core data port and the data-side slaves (data RAM, debugport controller).
// - Decodes each core request by address and forwards it to one of N_SLAVES slave ports.
// - Routes each slave's in-order response back to the core.
// - Answers unmapped addresses from an internal error responder.
// - Tracks up to OUTSTANDING granted-but-unanswered requests in an ID FIFO.
// PARAMETERS
// - N_SLAVES        2                           number of slave ports
// - SLV_BASE        {32'h8000_0000,32'h0001_0000} packed [N_SLAVES*32]; slot k = base of slave k
// - SLV_MASK        {32'hFFFF_F000,32'hFFFF_0000} packed [N_SLAVES*32]; hit[k] = (addr&mask)==base
// - OUTSTANDING     2                           ID FIFO depth (>=1)
// - TIMEOUT_CYCLES  64                          response timeout, used only with DBUS_TIMEOUT_EN
// PORTS
// - clk               in   1            clock
// - rst               in   1            synchronous reset, active-low
// - data_req_i        in   1            core request
// - data_we_i         in   1            write enable
// - data_be_i         in   4            byte enables
// - data_addr_i       in   32           address
// - data_wdata_i      in   32           write data
// - data_wdata_intg_i in   7            write data integrity
// - data_gnt_o        out  1            request accepted
// - data_rvalid_o     out  1            response valid
// - data_rdata_o      out  32           read data
// - data_rdata_intg_o out  7            read data integrity
// - data_err_o        out  1            response error
// - s_req_o           out  N_SLAVES     per-slave request
// - s_we_o/s_be_o/s_addr_o/s_wdata_o/s_wdata_intg_o  out  1/4/32/32/7  broadcast copies of core fields
// - s_gnt_i           in   N_SLAVES     per-slave grant
// - s_rvalid_i        in   N_SLAVES     per-slave response valid
// - s_err_i           in   N_SLAVES     per-slave response error
// - s_rdata_i         in   N_SLAVES*32  per-slave read data, slot k
// - s_rdata_intg_i    in   N_SLAVES*7   per-slave read integrity, slot k
// BEHAVIOUR
// - Reset (rst==0 at posedge): FIFO emptied, all state cleared.
//   Outputs while FIFO empty: s_req_o=0, data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, data_rdata_intg_o=0.
// - Decode: lowest-index hit wins, giving tgt = k. No hit gives tgt = ERR (ID value N_SLAVES).
// - Issue gate: can_issue = !full && (empty || tail_id==tgt). A full FIFO always blocks; no same-cycle push-on-pop, so no rvalid->gnt path.
// - Slave requests: s_req_o[k] = data_req_i & (tgt==k) & can_issue.
// - Core grant: data_gnt_o = can_issue & (tgt==ERR ? data_req_i : s_gnt_i[tgt]). Combinational, zero added latency.
// - Push: tgt into FIFO on data_req_i & data_gnt_o.
// - Response, head==k: data_rvalid_o=s_rvalid_i[k]. rdata/intg/err are muxed from slot k. Pop on s_rvalid_i[k].
// - Response, head==ERR: data_rvalid_o=1, data_err_o=1, rdata=0, intg=0, popped the same cycle. The error response is therefore exactly 1 cycle after its grant when it is at head.
// - An s_rvalid_i from a slave that is not at head, or with the FIFO empty, is a protocol violation. It is dropped; a simulation assertion fires.
// - Reset mid-operation: outstanding IDs are discarded; slave responses arriving after reset are dropped.
// - Push and pop in the same cycle are allowed when not full. Occupancy count is unchanged.
// CONFIGURATION
// - DBUS_TIMEOUT_EN defined:
//   - A cycle counter runs while the FIFO is non-empty; it clears on every pop.
//   - If it reaches TIMEOUT_CYCLES-1 with no pop that cycle: data_rvalid_o=1, data_err_o=1, rdata=0; head popped.
//   - If head was slave k: stale[k]++ (width clog2(OUTSTANDING+1)).
//   - While stale[k]!=0: each s_rvalid_i[k] is swallowed (stale[k]--), and new issue to slave k is blocked.
// - DBUS_TIMEOUT_EN undefined: no counter, no stale logic. A hung slave stalls the bus indefinitely.
// TESTING
// - Read 0x0001_0004, slave0 gnt same cycle, rvalid 2 cycles later with 32'hDEADBEEF -> core sees gnt same cycle, rdata DEADBEEF, err=0.
// - Write 0x8000_0000 wdata 0x5A, be=4'h1 -> s_req_o=2'b10, broadcast fields match; s_rvalid_i[1] -> data_rvalid_o=1.
// - Access 0x4000_0000 (unmapped) -> gnt same cycle, next cycle rvalid=1, err=1, rdata=0; no s_req_o asserted.
// - Two back-to-back slave0 reads, rvalid withheld -> both granted, third req held (gnt=0) until first response pops.
// - Slave0 read outstanding, then slave1 req -> slave1 blocked (s_req_o[1]=0) until slave0 response.
// - DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave0 never answers -> err response 8 cycles after gnt; later s_rvalid_i[0] swallowed; rst=0 mid-transaction -> FIFO empty, outputs 0.

Source files
------------

// File: rtl/data_bus_demux.sv
// -----------------------------------------------------------------------------
// data_bus_demux
//
// Purpose:
//   Sits between the core data port and the data-side slaves (data RAM,
//   debug port controller). Each core request is decoded by address and
//   forwarded to one of N_SLAVES slave ports. Unmapped addresses go to an
//   internal error responder. In-order responses are routed back to the core
//   using a FIFO of target IDs (depth OUTSTANDING). The error responder uses
//   ID N_SLAVES.
//
// Optional feature macro: DBUS_TIMEOUT_EN
//   When defined, a response watchdog forces an error response after
//   TIMEOUT_CYCLES cycles at the FIFO head. It counts the responses it has
//   abandoned per slave, so that those late responses are swallowed.
//   When undefined, a hung slave stalls the bus.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   data_*_i / data_*_o       core side: req/we/be/addr/wdata/intg in,
//                             gnt/rvalid/rdata/intg/err out
//   s_req_o                   per-slave request (one-hot or zero)
//   s_we_o .. s_wdata_intg_o  broadcast copies of the core request fields
//   s_gnt_i, s_rvalid_i,
//   s_err_i                   per-slave handshake/response bits
//   s_rdata_i, s_rdata_intg_i per-slave read data, slot k = slave k
// -----------------------------------------------------------------------------
module data_bus_demux #(
    parameter int                      N_SLAVES       = 2,
    parameter logic [N_SLAVES*32-1:0]  SLV_BASE       = {32'h8000_0000, 32'h0001_0000},
    parameter logic [N_SLAVES*32-1:0]  SLV_MASK       = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter int                      OUTSTANDING    = 2,
    parameter int                      TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_req_i,
    input  logic                     data_we_i,
    input  logic [3:0]               data_be_i,
    input  logic [31:0]              data_addr_i,
    input  logic [31:0]              data_wdata_i,
    input  logic [6:0]               data_wdata_intg_i,
    output logic                     data_gnt_o,
    output logic                     data_rvalid_o,
    output logic [31:0]              data_rdata_o,
    output logic [6:0]               data_rdata_intg_o,
    output logic                     data_err_o,
    output logic [N_SLAVES-1:0]      s_req_o,
    output logic                     s_we_o,
    output logic [3:0]               s_be_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_wdata_o,
    output logic [6:0]               s_wdata_intg_o,
    input  logic [N_SLAVES-1:0]      s_gnt_i,
    input  logic [N_SLAVES-1:0]      s_rvalid_i,
    input  logic [N_SLAVES-1:0]      s_err_i,
    input  logic [N_SLAVES*32-1:0]   s_rdata_i,
    input  logic [N_SLAVES*7-1:0]    s_rdata_intg_i
);

    localparam int IDW  = $clog2(N_SLAVES + 1);
    localparam int PTRW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNTW = $clog2(OUTSTANDING + 1);
    localparam logic [IDW-1:0]  ERR_ID   = IDW'(N_SLAVES);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(OUTSTANDING);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(OUTSTANDING - 1);

    // Request fields are broadcast; only s_req_o qualifies them.
    assign s_we_o         = data_we_i;
    assign s_be_o         = data_be_i;
    assign s_addr_o       = data_addr_i;
    assign s_wdata_o      = data_wdata_i;
    assign s_wdata_intg_o = data_wdata_intg_i;

    // ---------------------------------------------------------------- decode
    logic [N_SLAVES-1:0] hit;
    logic [IDW-1:0]      tgt;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
            assign hit[gi] = (data_addr_i & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32];
        end
    endgenerate

    // Scan from the top down so that the lowest-index hit is assigned last and wins.
    always_comb begin
        tgt = ERR_ID;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (hit[k]) tgt = IDW'(k);
        end
    end

    // ------------------------------------------------------------- ID FIFO
    logic [IDW-1:0]  fifo_q [OUTSTANDING];
    logic [PTRW-1:0] rptr_q, rptr_d, wptr_q, wptr_d, tail_ptr;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            empty, full;
    logic [IDW-1:0]  head_id, tail_id;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign tail_ptr = (wptr_q == '0) ? LAST_PTR : wptr_q - 1'b1;
    assign head_id  = fifo_q[rptr_q];
    assign tail_id  = fifo_q[tail_ptr];

    // ------------------------------------------------- timeout / stale state
    logic [N_SLAVES-1:0] swallow;
    logic                tgt_stale;
    logic                timeout_fire;
    logic                normal_pop;

`ifdef DBUS_TIMEOUT_EN
    localparam int TOW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TOW-1:0]  to_cnt_q, to_cnt_d;
    logic [CNTW-1:0] stale_q [N_SLAVES];
    logic [CNTW-1:0] stale_d [N_SLAVES];

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_swallow
            // A late answer to an abandoned request is consumed silently.
            assign swallow[gi] = s_rvalid_i[gi] & (stale_q[gi] != '0);
        end
    endgenerate

    always_comb begin
        tgt_stale = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (tgt == IDW'(k) && stale_q[k] != '0) tgt_stale = 1'b1;
        end
    end

    assign timeout_fire = !empty && !normal_pop && (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));
`else
    assign swallow      = '0;
    assign tgt_stale    = 1'b0;
    assign timeout_fire = 1'b0;
`endif

    // --------------------------------------------------------- issue side
    logic can_issue;
    logic tgt_gnt;
    logic push, pop;

    // rst gates issue so that nothing is granted in a cycle whose push would be discarded.
    assign can_issue = rst && !full && (empty || tail_id == tgt) && !tgt_stale;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_req
            assign s_req_o[gi] = data_req_i & (tgt == IDW'(gi)) & can_issue;
        end
    endgenerate

    // --------------------------------------------------------- response mux
    logic        head_rv;
    logic        head_err;
    logic [31:0] head_rdata;
    logic [6:0]  head_intg;

    always_comb begin
        tgt_gnt    = 1'b0;
        head_rv    = 1'b0;
        head_err   = 1'b0;
        head_rdata = '0;
        head_intg  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (tgt == IDW'(k)) tgt_gnt = s_gnt_i[k];
            if (head_id == IDW'(k)) begin
                head_rv    = s_rvalid_i[k] & ~swallow[k];
                head_err   = s_err_i[k];
                head_rdata = s_rdata_i[k*32 +: 32];
                head_intg  = s_rdata_intg_i[k*7 +: 7];
            end
        end
    end

    logic slv_pop, err_pop;

    assign data_gnt_o = can_issue & ((tgt == ERR_ID) ? data_req_i : tgt_gnt);
    assign push       = data_req_i & data_gnt_o;

    assign slv_pop    = !empty && head_rv;
    assign err_pop    = !empty && (head_id == ERR_ID);
    assign normal_pop = slv_pop | err_pop;
    assign pop        = normal_pop | timeout_fire;

    assign data_rvalid_o     = pop;
    assign data_err_o        = err_pop | timeout_fire | (slv_pop & head_err);
    assign data_rdata_o      = slv_pop ? head_rdata : '0;
    assign data_rdata_intg_o = slv_pop ? head_intg : '0;

    // --------------------------------------------------------- next state
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        if (pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + CNTW'(1);
        if (pop && !push) cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (rst && push) fifo_q[wptr_q] <= tgt;
    end

`ifdef DBUS_TIMEOUT_EN
    always_comb begin
        to_cnt_d = (pop || empty) ? '0 : to_cnt_q + TOW'(1);
        for (int k = 0; k < N_SLAVES; k++) begin
            stale_d[k] = stale_q[k];
            if (timeout_fire && head_id == IDW'(k)) stale_d[k] = stale_d[k] + CNTW'(1);
            if (swallow[k]) stale_d[k] = stale_d[k] - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            for (int k = 0; k < N_SLAVES; k++) stale_q[k] <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            for (int k = 0; k < N_SLAVES; k++) stale_q[k] <= stale_d[k];
        end
    end
`endif

`ifndef SYNTHESIS
    // A slave response must belong to the current head, or be a swallowed stale one.
    logic [N_SLAVES-1:0] head_sel;
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_hsel
            assign head_sel[gi] = !empty && (head_id == IDW'(gi));
        end
    endgenerate

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst)
        (s_rvalid_i & ~swallow & ~head_sel) == '0);
`endif

endmodule

// File: tb/tb_data_bus_demux.sv
// -----------------------------------------------------------------------------
// tb_data_bus_demux
//
// Purpose: self-checking bench for data_bus_demux. A cycle-by-cycle vector
//   table drives the core and slave inputs and gives the expected outputs.
//   Hand-written sequences cover the broadcast fields, a reset in the middle
//   of a transaction and, with DBUS_TIMEOUT_EN defined, the timeout path.
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_data_bus_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [6:0]  data_wdata_intg_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic [1:0]  s_req_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [6:0]  s_wdata_intg_o;
    logic [1:0]  s_gnt_i, s_rvalid_i, s_err_i;
    logic [63:0] s_rdata_i;
    logic [13:0] s_rdata_intg_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_bus_demux #(
        .N_SLAVES       (2),
        .OUTSTANDING    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .data_req_i        (data_req_i),
        .data_we_i         (data_we_i),
        .data_be_i         (data_be_i),
        .data_addr_i       (data_addr_i),
        .data_wdata_i      (data_wdata_i),
        .data_wdata_intg_i (data_wdata_intg_i),
        .data_gnt_o        (data_gnt_o),
        .data_rvalid_o     (data_rvalid_o),
        .data_rdata_o      (data_rdata_o),
        .data_rdata_intg_o (data_rdata_intg_o),
        .data_err_o        (data_err_o),
        .s_req_o           (s_req_o),
        .s_we_o            (s_we_o),
        .s_be_o            (s_be_o),
        .s_addr_o          (s_addr_o),
        .s_wdata_o         (s_wdata_o),
        .s_wdata_intg_o    (s_wdata_intg_o),
        .s_gnt_i           (s_gnt_i),
        .s_rvalid_i        (s_rvalid_i),
        .s_err_i           (s_err_i),
        .s_rdata_i         (s_rdata_i),
        .s_rdata_intg_i    (s_rdata_intg_i)
    );

    // Integrity values per slave slot are fixed so they identify the slot.
    localparam logic [6:0] INTG0 = 7'h11;
    localparam logic [6:0] INTG1 = 7'h22;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [1:0]  sg;
        logic [1:0]  sv;
        logic [1:0]  se;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        e_gnt;
        logic [1:0]  e_sreq;
        logic        e_rv;
        logic        e_err;
        logic [31:0] e_rdata;
        logic [6:0]  e_intg;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic req, input logic [31:0] addr,
                                input logic [1:0] sg, input logic [1:0] sv, input logic [1:0] se,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic eg, input logic [1:0] esr, input logic erv,
                                input logic eer, input logic [31:0] ed, input logic [6:0] ei);
        vec_t v;
        v.req = req; v.addr = addr; v.sg = sg; v.sv = sv; v.se = se;
        v.rd0 = rd0; v.rd1 = rd1;
        v.e_gnt = eg; v.e_sreq = esr; v.e_rv = erv; v.e_err = eer;
        v.e_rdata = ed; v.e_intg = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic [1:0] sg,
                         input logic [1:0] sv, input logic [1:0] se,
                         input logic [31:0] rd0, input logic [31:0] rd1);
        data_req_i        = req;
        data_we_i         = 1'b0;
        data_be_i         = 4'hF;
        data_addr_i       = addr;
        data_wdata_i      = 32'h0;
        data_wdata_intg_i = 7'h0;
        s_gnt_i           = sg;
        s_rvalid_i        = sv;
        s_err_i           = se;
        s_rdata_i         = {rd1, rd0};
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"},    32'(data_gnt_o),        32'h0);
        chk({tag, ".sreq"},   32'(s_req_o),           32'h0);
        chk({tag, ".rvalid"}, 32'(data_rvalid_o),     32'h0);
        chk({tag, ".err"},    32'(data_err_o),        32'h0);
        chk({tag, ".rdata"},  data_rdata_o,           32'h0);
        chk({tag, ".intg"},   32'(data_rdata_intg_o), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        s_rdata_intg_i = {INTG1, INTG0};
        rst = 1'b0;
        drive(1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 chk_idle("rst.held");
        $display("txn reset held: gnt=%b rv=%b", data_gnt_o, data_rvalid_o);
        rst = 1'b1;
        @(negedge clk);
        #2 chk_idle("rst.after");
        $display("txn reset released: gnt=%b rv=%b", data_gnt_o, data_rvalid_o);

        // req addr sg sv se rd0 rd1 | gnt sreq rv err rdata intg
        vecs.push_back(mk(1, 32'h0001_0004, 2'b01, 2'b00, 2'b00, 0, 0,            1, 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 0,            0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b01, 2'b00, 32'hDEADBEEF, 0, 0, 2'b00, 1, 0, 32'hDEADBEEF, INTG0));
        vecs.push_back(mk(1, 32'h8000_0000, 2'b10, 2'b00, 2'b00, 0, 0,            1, 2'b10, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b10, 2'b10, 32'h12345678, 32'hCAFE0001, 0, 2'b00, 1, 1, 32'hCAFE0001, INTG1));
        // unmapped: granted without slave grant, error response next cycle
        vecs.push_back(mk(1, 32'h4000_0000, 2'b00, 2'b00, 2'b00, 0, 0,            1, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 0,            0, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 0,            0, 2'b00, 0, 0, 0, 0));
        // fill the FIFO with two slave0 reads, third held
        vecs.push_back(mk(1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0,            1, 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0001_0008, 2'b01, 2'b00, 2'b00, 0, 0,            1, 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0001_000C, 2'b01, 2'b00, 2'b00, 0, 0,            0, 2'b00, 0, 0, 0, 0));
        // full: the popping cycle still blocks issue
        vecs.push_back(mk(1, 32'h0001_000C, 2'b01, 2'b01, 2'b00, 32'h11111111, 0, 0, 2'b00, 1, 0, 32'h11111111, INTG0));
        vecs.push_back(mk(1, 32'h0001_000C, 2'b01, 2'b00, 2'b00, 0, 0,            1, 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b01, 2'b00, 32'h22222222, 0, 0, 2'b00, 1, 0, 32'h22222222, INTG0));
        // slave1 blocked behind outstanding slave0
        vecs.push_back(mk(1, 32'h8000_0004, 2'b10, 2'b00, 2'b00, 0, 0,            0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0004, 2'b10, 2'b01, 2'b00, 32'h33333333, 0, 0, 2'b00, 1, 0, 32'h33333333, INTG0));
        vecs.push_back(mk(1, 32'h8000_0004, 2'b10, 2'b00, 2'b00, 0, 0,            1, 2'b10, 0, 0, 0, 0));
        // slave stalls grant: request visible, no core grant
        vecs.push_back(mk(1, 32'h8000_0010, 2'b00, 2'b00, 2'b00, 0, 0,            0, 2'b10, 0, 0, 0, 0));
        // push and pop in the same cycle
        vecs.push_back(mk(1, 32'h8000_0010, 2'b10, 2'b10, 2'b00, 0, 32'h44444444, 1, 2'b10, 1, 0, 32'h44444444, INTG1));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b10, 2'b00, 0, 32'h55555555, 0, 2'b00, 1, 0, 32'h55555555, INTG1));
        // back-to-back unmapped accesses
        vecs.push_back(mk(1, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 0, 0,            1, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4000_0000, 2'b00, 2'b00, 2'b00, 0, 0,            1, 2'b00, 1, 1, 0, 0));
        // slave0 blocked behind error entry while it is answered
        vecs.push_back(mk(1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0,            0, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0,            1, 2'b01, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b01, 2'b00, 32'h77777777, 0, 0, 2'b00, 1, 0, 32'h77777777, INTG0));
        // just outside each window -> unmapped
        vecs.push_back(mk(1, 32'h8000_1000, 2'b10, 2'b00, 2'b00, 0, 0,            1, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0002_0000, 2'b01, 2'b00, 2'b00, 0, 0,            1, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 0,            0, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 0,            0, 2'b00, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].addr, vecs[i].sg, vecs[i].sv, vecs[i].se,
                  vecs[i].rd0, vecs[i].rd1);
            #2;
            chk($sformatf("v%0d.gnt", i),    32'(data_gnt_o),        32'(vecs[i].e_gnt));
            chk($sformatf("v%0d.sreq", i),   32'(s_req_o),           32'(vecs[i].e_sreq));
            chk($sformatf("v%0d.rvalid", i), 32'(data_rvalid_o),     32'(vecs[i].e_rv));
            chk($sformatf("v%0d.err", i),    32'(data_err_o),        32'(vecs[i].e_err));
            chk($sformatf("v%0d.rdata", i),  data_rdata_o,           vecs[i].e_rdata);
            chk($sformatf("v%0d.intg", i),   32'(data_rdata_intg_o), 32'(vecs[i].e_intg));
            $display("txn v%0d: req=%b addr=%h gnt=%b sreq=%b rv=%b err=%b rdata=%h",
                     i, vecs[i].req, vecs[i].addr, data_gnt_o, s_req_o,
                     data_rvalid_o, data_err_o, data_rdata_o);
        end

        // Broadcast fields on a write to slave1
        @(negedge clk);
        drive(1'b1, 32'h8000_0000, 2'b10, 2'b00, 2'b00, 0, 0);
        data_we_i = 1'b1; data_be_i = 4'h1;
        data_wdata_i = 32'h0000_005A; data_wdata_intg_i = 7'h3C;
        #2;
        chk("wr.sreq",  32'(s_req_o),        32'h2);
        chk("wr.gnt",   32'(data_gnt_o),     32'h1);
        chk("wr.we",    32'(s_we_o),         32'h1);
        chk("wr.be",    32'(s_be_o),         32'h1);
        chk("wr.addr",  s_addr_o,            32'h8000_0000);
        chk("wr.wdata", s_wdata_o,           32'h0000_005A);
        chk("wr.wintg", 32'(s_wdata_intg_o), 32'h3C);
        $display("txn write: sreq=%b we=%b be=%h wdata=%h", s_req_o, s_we_o, s_be_o, s_wdata_o);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00, 2'b10, 2'b00, 0, 0);
        #2;
        chk("wr.rvalid", 32'(data_rvalid_o), 32'h1);
        chk("wr.err",    32'(data_err_o),    32'h0);
        $display("txn write response: rv=%b err=%b", data_rvalid_o, data_err_o);

        // Reset with a slave0 read outstanding
        @(negedge clk);
        drive(1'b1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0);
        #2 chk("mr.gnt", 32'(data_gnt_o), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("mr.rst_gnt",  32'(data_gnt_o), 32'h0);
        chk("mr.rst_sreq", 32'(s_req_o),    32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0);
        #2 chk_idle("mr.after");
        $display("txn mid reset: rv=%b gnt=%b", data_rvalid_o, data_gnt_o);
        @(negedge clk);
        drive(1'b1, 32'h8000_0000, 2'b10, 2'b00, 2'b00, 0, 0);
        #2;
        chk("mr.s1_gnt",  32'(data_gnt_o), 32'h1);
        chk("mr.s1_sreq", 32'(s_req_o),    32'h2);
        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00, 2'b10, 2'b00, 0, 32'h0BAD_F00D);
        #2;
        chk("mr.s1_rv",    32'(data_rvalid_o), 32'h1);
        chk("mr.s1_rdata", data_rdata_o,       32'h0BAD_F00D);
        $display("txn post-reset read: rv=%b rdata=%h", data_rvalid_o, data_rdata_o);

`ifdef DBUS_TIMEOUT_EN
        begin : timeout_seq
            int  lat;
            bit  seen;
            lat  = 0;
            seen = 1'b0;
            @(negedge clk);
            drive(1'b1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0);
            #2 chk("to.gnt", 32'(data_gnt_o), 32'h1);
            for (int c = 1; c <= 20 && !seen; c++) begin
                @(negedge clk);
                drive(1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0);
                #2;
                if (data_rvalid_o) begin
                    seen = 1'b1;
                    lat  = c;
                    chk("to.err",   32'(data_err_o), 32'h1);
                    chk("to.rdata", data_rdata_o,    32'h0);
                end
            end
            chk("to.seen",    32'(seen), 32'h1);
            chk("to.latency", 32'(lat),  32'h8);
            $display("txn timeout: latency=%0d", lat);
            @(negedge clk);
            drive(1'b1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0);
            #2 chk("to.stale_gnt", 32'(data_gnt_o), 32'h0);
            @(negedge clk);
            drive(1'b0, 32'h0, 2'b00, 2'b01, 2'b00, 32'h9999_9999, 0);
            #2 chk("to.swallow_rv", 32'(data_rvalid_o), 32'h0);
            @(negedge clk);
            drive(1'b1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0);
            #2 chk("to.reissue_gnt", 32'(data_gnt_o), 32'h1);
            @(negedge clk);
            drive(1'b0, 32'h0, 2'b00, 2'b01, 2'b00, 32'hA5A5_A5A5, 0);
            #2;
            chk("to.resp_rv",    32'(data_rvalid_o), 32'h1);
            chk("to.resp_rdata", data_rdata_o,       32'hA5A5_A5A5);
            $display("txn timeout recovery: rv=%b rdata=%h", data_rvalid_o, data_rdata_o);
            // reset while a request waits for its timeout
            @(negedge clk);
            drive(1'b1, 32'h0001_0000, 2'b01, 2'b00, 2'b00, 0, 0);
            @(negedge clk);
            drive(1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            #2 chk_idle("to.reset");
            $display("txn timeout reset: rv=%b", data_rvalid_o);
        end
`endif

        @(negedge clk);
        drive(1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
